// File: rtl/rom_share_pkg.sv
// Shared types and default parameters for the download/shared-ROM controller.
package rom_share_pkg;

    localparam int unsigned ADDR_W_DEF   = 16;
    localparam int unsigned ROM_SIZE_DEF = 65536;
    localparam int unsigned HOLD_CYC_DEF = 256;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } top_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_GFX = 1'b1
    } req_id_e;

endpackage

// File: rtl/rom_share_rr.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module rom_share_rr
    import rom_share_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last,
    output logic       valid,
    output req_id_e    grant
);

    always_comb begin
        valid = |req;
        grant = REQ_CPU;
        case (req)
            2'b01:   grant = REQ_CPU;
            2'b10:   grant = REQ_GFX;
            2'b11:   grant = (last == REQ_CPU) ? REQ_GFX : REQ_CPU;
            default: grant = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/rom_share_ctrl.sv
// Loads the game ROM from the HPS download port, holds the core in reset, then
// time-shares the single-port ROM RAM between the CPU and the gfx fetcher.
module rom_share_ctrl
    import rom_share_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ROM_SIZE = ROM_SIZE_DEF,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic              clock_40,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [7:0]        cpu_data,
    input  logic              gfx_req,
    input  logic [ADDR_W-1:0] gfx_addr,
    output logic              gfx_ack,
    output logic [7:0]        gfx_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              core_reset
);

    localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYC - 1);

    top_state_e        state_q, state_d;
    rd_state_e         rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              core_reset_q, core_reset_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              gfx_ack_q, gfx_ack_d;
    logic [7:0]        cpu_data_q, cpu_data_d;
    logic [7:0]        gfx_data_q, gfx_data_d;
    req_id_e           last_q, last_d;
    req_id_e           winner_q, winner_d;

    logic              in_range;
    logic [1:0]        elig;
    logic              rr_valid;
    req_id_e           rr_grant;

    assign in_range = (32'(dl_addr) < ROM_SIZE);
    // A requester whose ack is showing this cycle is finishing, not asking again.
    assign elig     = {gfx_req & ~gfx_ack_q, cpu_req & ~cpu_ack_q};

    rom_share_rr u_rr (
        .req   (elig),
        .last  (last_q),
        .valid (rr_valid),
        .grant (rr_grant)
    );

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        gfx_ack_d   = 1'b0;
        cpu_data_d  = cpu_data_q;
        gfx_data_d  = gfx_data_q;
        last_d      = last_q;
        winner_d    = winner_q;

        if (dl_active) begin
            // Download pre-empts everything; any in-flight read is dropped silently.
            state_d = ST_LOAD;
            rd_d    = R_IDLE;
            if (state_q == ST_LOAD && dl_wr && in_range) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = dl_addr;
                mem_wdata_d = dl_data;
            end
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_INIT;
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    unique case (rd_q)
                        R_IDLE: begin
                            if (rr_valid) begin
                                mem_addr_d = (rr_grant == REQ_GFX) ? gfx_addr : cpu_addr;
                                winner_d   = rr_grant;
                                rd_d       = R_ADDR;
                            end
                        end
                        R_ADDR: rd_d = R_DATA;
                        R_DATA: begin
                            if (winner_q == REQ_GFX) begin
                                gfx_data_d = mem_rdata;
                                gfx_ack_d  = 1'b1;
                            end else begin
                                cpu_data_d = mem_rdata;
                                cpu_ack_d  = 1'b1;
                            end
                            last_d = winner_q;
                            rd_d   = R_IDLE;
                        end
                        default: rd_d = R_IDLE;
                    endcase
                end
                default: state_d = ST_LOAD;
            endcase
        end

        core_reset_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clock_40 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_LOAD;
            rd_q         <= R_IDLE;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            gfx_ack_q    <= 1'b0;
            cpu_data_q   <= '0;
            gfx_data_q   <= '0;
            last_q       <= REQ_CPU;
            winner_q     <= REQ_CPU;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            gfx_ack_q    <= gfx_ack_d;
            cpu_data_q   <= cpu_data_d;
            gfx_data_q   <= gfx_data_d;
            last_q       <= last_d;
            winner_q     <= winner_d;
        end
    end

    assign core_reset = core_reset_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign gfx_ack    = gfx_ack_q;
    assign cpu_data   = cpu_data_q;
    assign gfx_data   = gfx_data_q;

endmodule

// File: tb/tb_rom_share_ctrl.sv
// Directed plus randomized bench for rom_share_ctrl against a behavioural ROM model.
module tb_rom_share_ctrl;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned ROM_SIZE = 32'h4000;
    localparam int unsigned HOLD_CYC = 8;

    logic              clock_40 = 1'b0;
    logic              reset_n  = 1'b1;
    logic              dl_active = 1'b0;
    logic              dl_wr     = 1'b0;
    logic [ADDR_W-1:0] dl_addr   = '0;
    logic [7:0]        dl_data   = '0;
    logic              cpu_req   = 1'b0;
    logic [ADDR_W-1:0] cpu_addr  = '0;
    logic              cpu_ack;
    logic [7:0]        cpu_data;
    logic              gfx_req   = 1'b0;
    logic [ADDR_W-1:0] gfx_addr  = '0;
    logic              gfx_ack;
    logic [7:0]        gfx_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;
    logic              core_reset;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference: ROM contents, data holding registers, last served requester.
    logic [7:0]  ref_rom [0:65535];
    logic [15:0] addr_q[$];
    logic [7:0]  exp_cpu_data;
    logic [7:0]  exp_gfx_data;
    bit          ref_last_gfx;

    // Single-port synchronous RAM standing in for the ROM storage.
    logic [7:0] ram [0:65535];
    always @(posedge clock_40) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always #5 clock_40 = ~clock_40;

    rom_share_ctrl #(
        .ADDR_W   (ADDR_W),
        .ROM_SIZE (ROM_SIZE),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clock_40   (clock_40),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ack    (cpu_ack),
        .cpu_data   (cpu_data),
        .gfx_req    (gfx_req),
        .gfx_addr   (gfx_addr),
        .gfx_ack    (gfx_ack),
        .gfx_data   (gfx_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .core_reset (core_reset)
    );

    task automatic step();
        @(posedge clock_40);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_ack"}, cpu_ack, 0);
        check({tag, "_gfx_ack"}, gfx_ack, 0);
        check({tag, "_cpu_data"}, cpu_data, 0);
        check({tag, "_gfx_data"}, gfx_data, 0);
        exp_cpu_data = 8'h00;
        exp_gfx_data = 8'h00;
        ref_last_gfx = 1'b0;
    endtask

    // Counts clocks from now until core_reset drops; the release takes HOLD_CYC+1.
    task automatic wait_release(input string tag);
        int n = 0;
        do begin
            step();
            n++;
            if (core_reset) check({tag, "_no_write"}, mem_we, 0);
        end while (core_reset && n < 4 * HOLD_CYC + 8);
        check({tag, "_release_cycles"}, n, HOLD_CYC + 1);
    endtask

    task automatic dl_write(input logic [15:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        step();
        dl_wr = 1'b0;
        if (32'(a) < ROM_SIZE) begin
            check("wr_we", mem_we, 1);
            check("wr_addr", mem_addr, a);
            check("wr_data", mem_wdata, d);
            ref_rom[a] = d;
            addr_q.push_back(a);
        end else begin
            check("wr_out_of_range", mem_we, 0);
        end
        step();
        check("wr_one_cycle", mem_we, 0);
    endtask

    task automatic do_read(input bit gfx, input logic [15:0] a);
        int n = 0;
        logic mine;
        if (gfx) begin gfx_req = 1'b1; gfx_addr = a; end
        else     begin cpu_req = 1'b1; cpu_addr = a; end
        do begin
            step();
            n++;
            mine = gfx ? gfx_ack : cpu_ack;
            check("rd_other_ack", gfx ? cpu_ack : gfx_ack, 0);
        end while (!mine && n < 12);
        cpu_req = 1'b0;
        gfx_req = 1'b0;
        check("rd_latency", n, 3);
        if (gfx) exp_gfx_data = ref_rom[a];
        else     exp_cpu_data = ref_rom[a];
        check("rd_cpu_data", cpu_data, exp_cpu_data);
        check("rd_gfx_data", gfx_data, exp_gfx_data);
        ref_last_gfx = gfx;
        step();
        check("rd_ack_pulse", cpu_ack | gfx_ack, 0);
    endtask

    task automatic do_contend(input logic [15:0] ca, input logic [15:0] ga, input int acks);
        cpu_req  = 1'b1;
        cpu_addr = ca;
        gfx_req  = 1'b1;
        gfx_addr = ga;
        for (int k = 0; k < acks; k++) begin
            int n = 0;
            bit exp_gfx;
            exp_gfx = !ref_last_gfx;
            do begin
                step();
                n++;
            end while (!(cpu_ack || gfx_ack) && n < 12);
            if (k == acks - 1) begin
                cpu_req = 1'b0;
                gfx_req = 1'b0;
            end
            check("rr_latency", n, 3);
            check("rr_gfx_ack", gfx_ack, exp_gfx);
            check("rr_cpu_ack", cpu_ack, !exp_gfx);
            if (exp_gfx) exp_gfx_data = ref_rom[ga];
            else         exp_cpu_data = ref_rom[ca];
            check("rr_cpu_data", cpu_data, exp_cpu_data);
            check("rr_gfx_data", gfx_data, exp_gfx_data);
            ref_last_gfx = exp_gfx;
        end
        step();
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;

        // Power-on reset, then release with no download pending.
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock_40);
        #1;
        check_reset_vals("por");
        reset_n = 1'b1;
        wait_release("por");

        // Directed download of two bytes.
        dl_active = 1'b1;
        step();
        check("dl_core_reset", core_reset, 1);
        dl_write(16'h0000, 8'h3E);
        dl_write(16'h0001, 8'hC9);
        dl_active = 1'b0;
        wait_release("dl");

        do_read(1'b0, 16'h0001);
        check("single_read_c9", cpu_data, 8'hC9);
        do_read(1'b1, 16'h0000);
        check("gfx_read_3e", gfx_data, 8'h3E);

        // Stray download strobe while not downloading.
        dl_wr   = 1'b1;
        dl_addr = 16'h0005;
        dl_data = 8'h55;
        step();
        dl_wr = 1'b0;
        check("stray_wr", mem_we, 0);
        step();
        check("stray_wr2", mem_we, 0);

        do_contend(16'h0000, 16'h0001, 4);

        // Randomized download including range boundaries.
        dl_active = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            dl_write(16'($urandom_range(2, ROM_SIZE - 1)), 8'($urandom));
        end
        dl_write(16'(ROM_SIZE - 1), 8'hA5);
        dl_write(16'(ROM_SIZE), 8'h5A);
        dl_write(16'hFFFF, 8'h77);
        dl_active = 1'b0;
        wait_release("rand_dl");

        for (int i = 0; i < 20; i++) begin
            ra = addr_q[$urandom_range(0, addr_q.size() - 1)];
            rb = addr_q[$urandom_range(0, addr_q.size() - 1)];
            case ($urandom_range(0, 2))
                0:       do_read(1'b0, ra);
                1:       do_read(1'b1, ra);
                default: do_contend(ra, rb, 2 + int'($urandom_range(0, 2)));
            endcase
        end

        // Download starting while a CPU read sits in its address phase.
        cpu_req  = 1'b1;
        cpu_addr = 16'h0001;
        step();
        dl_active = 1'b1;
        step();
        check("abort_core_reset", core_reset, 1);
        check("abort_cpu_ack", cpu_ack, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_cpu_ack", cpu_ack, 0);
            check("abort_no_gfx_ack", gfx_ack, 0);
        end
        check("abort_cpu_data", cpu_data, exp_cpu_data);
        gfx_req  = 1'b1;
        gfx_addr = 16'h0000;
        repeat (3) step();
        check("load_ignores_gfx", gfx_ack, 0);
        check("load_gfx_data", gfx_data, exp_gfx_data);
        cpu_req = 1'b0;
        gfx_req = 1'b0;
        dl_write(16'h4000, 8'h11);
        dl_write(16'h0002, 8'h42);
        dl_active = 1'b0;
        wait_release("abort");
        do_read(1'b1, 16'h0002);
        check("abort_reload_read", gfx_data, 8'h42);

        // Reset pulsed in the middle of the hold period.
        dl_active = 1'b1;
        step();
        dl_active = 1'b0;
        repeat (3) step();
        check("hold_core_reset", core_reset, 1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        step();
        reset_n = 1'b1;
        wait_release("midrst");

        // After reset the gfx side wins the first tie.
        do_contend(16'h0001, 16'h0000, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rom_share_ctrl.md
ROM_SHARE_CTRL -- requirements
Module: rom_share_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: ROM byte-address width.
REQ-002 Parameter ROM_SIZE, default 65536: bytes accepted from download; higher addresses are discarded.
REQ-003 Parameter HOLD_CYC, default 256: clocks core_reset stays high after download ends.
REQ-004 clock_40  in  1  sole clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 dl_active  in  1  HPS download in progress.
REQ-007 dl_wr  in  1  one-cycle download byte strobe.
REQ-008 dl_addr  in  ADDR_W  download byte address.
REQ-009 dl_data  in  8  download byte.
REQ-010 cpu_req  in  1  CPU read request; held until cpu_ack.
REQ-011 cpu_addr  in  ADDR_W  CPU read address; stable while cpu_req high.
REQ-012 cpu_ack  out  1  one-cycle pulse; cpu_data valid in the same cycle.
REQ-013 cpu_data  out  8  CPU read data; holds until next CPU ack.
REQ-014 gfx_req, gfx_addr, gfx_ack, gfx_data: same directions, widths and rules as the CPU set, for the sprite/tile fetcher.
REQ-015 mem_addr  out  ADDR_W  registered address to the single-port synchronous ROM RAM.
REQ-016 mem_wdata  out  8  registered write data.
REQ-017 mem_we  out  1  registered write enable.
REQ-018 mem_rdata  in  8  RAM read data, valid 1 cycle after mem_addr.
REQ-019 core_reset  out  1  active-high reset to the game core.

Function
REQ-020 Top-level states: LOAD, HOLD, RUN. Read sub-states inside RUN: R_IDLE, R_ADDR, R_DATA.
REQ-021 Any state with dl_active=1 goes to LOAD the next cycle. An in-flight read is abandoned: no ack, data registers unchanged.
REQ-022 LOAD: dl_wr=1 with dl_addr<ROM_SIZE registers mem_we=1, mem_addr=dl_addr, mem_wdata=dl_data for exactly one cycle. Write latency is 1 clock.
REQ-023 LOAD: dl_wr with dl_addr>=ROM_SIZE produces no write. cpu_req and gfx_req are ignored.
REQ-024 LOAD with dl_active=0 goes to HOLD and loads a down-counter with HOLD_CYC-1.
REQ-025 HOLD decrements the counter each cycle and enters RUN the cycle after it reads 0.
REQ-026 core_reset=1 in LOAD and HOLD and 0 only in RUN. It is registered, so it falls on the same edge that enters RUN.
REQ-027 dl_wr while dl_active=0 is ignored in every state.
REQ-028 R_IDLE with at least one eligible request: register the winner's address to mem_addr, record the winner, go to R_ADDR. A requester is eligible if req=1 and its ack is not high this cycle.
REQ-029 R_ADDR goes to R_DATA unconditionally.
REQ-030 R_DATA: capture mem_rdata into the winner's data register, pulse the winner's ack the following cycle, return to R_IDLE.
REQ-031 Uncontested read latency: ack is high 3 cycles after req is first sampled in R_IDLE. Throughput is one read per 3 cycles.
REQ-032 Contention is resolved 2-way round-robin: the requester not served last wins. After reset the last-served requester is CPU, so GFX wins the first tie.
REQ-033 mem_we=0 throughout RUN. mem_addr holds its last value when no access is active.
REQ-034 A request dropped before ack is protocol misuse. The started read still completes and acks.

Reset
REQ-035 While reset_n=0: state=LOAD, core_reset=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ack=gfx_ack=0, cpu_data=gfx_data=0, hold counter=0, last-served=CPU.
REQ-036 After reset_n rises with dl_active=0, the block passes LOAD->HOLD and releases core_reset after HOLD_CYC+1 cycles.

Structure
REQ-037 Package rom_share_pkg holds the top-state and read-state enums, the requester-id type, and the defaults for ADDR_W, ROM_SIZE and HOLD_CYC.
REQ-038 One sub-module, rom_share_rr: a 2-way round-robin picker taking req[1:0] and last-served, returning the grant id. Everything else stays in rom_share_ctrl.

Verification
REQ-039 Download scenario: dl_active=1, writes 0x0000=0x3E, 0x0001=0xC9, then dl_active=0. Required: one mem_we pulse per byte, each 1 cycle after dl_wr; core_reset falls exactly HOLD_CYC+1 cycles after dl_active falls.
REQ-040 Single read: in RUN, cpu_req with cpu_addr=0x0001. Required: cpu_ack 3 cycles later with cpu_data=0xC9; gfx_ack stays 0.
REQ-041 Contention: cpu_req and gfx_req rise together and stay high. Required: first ack is gfx_ack, next ack is cpu_ack 3 cycles later, then acks alternate.
REQ-042 Abort: dl_active rises during R_ADDR. Required: no ack, core_reset=1 next cycle, state LOAD.
REQ-043 Out-of-range write: ROM_SIZE=0x4000, dl_wr at 0x4000. Required: mem_we stays 0.
REQ-044 Mid-operation reset: reset_n pulsed low during HOLD. Required: all outputs at reset values immediately, full hold sequence repeats.
